wb_ext_arbiter: RTL

Shared external-memory arbiter downstream of the per-tile wb_ext_* master ports in the distributed-memory system. It takes NODES flattened Wishbone B3 master ports and multiplexes them onto one Wishbone slave port, typically a DDR or SRAM controller. Arbitration is round-robin with burst (CTI) hold. A bus-timeout watchdog guarantees that a dead slave cannot hang a tile.

---
 rtl/wb_ext_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_ext_arbiter.sv
// Round-robin Wishbone arbiter: NODES masters onto one slave, grant held for the whole cyc.
// Watchdog aborts a stalled transfer with err after TIMEOUT unanswered strobe cycles.
module wb_ext_arbiter #(
   parameter int NODES   = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NODES*AW-1:0]   m_adr_i,
   input  logic [NODES*DW-1:0]   m_dat_i,
   input  logic [NODES*DW/8-1:0] m_sel_i,
   input  logic [NODES-1:0]      m_cyc_i,
   input  logic [NODES-1:0]      m_stb_i,
   input  logic [NODES-1:0]      m_we_i,
   input  logic [NODES*3-1:0]    m_cti_i,
   input  logic [NODES*2-1:0]    m_bte_i,
   output logic [NODES-1:0]      m_ack_o,
   output logic [NODES-1:0]      m_err_o,
   output logic [NODES-1:0]      m_rty_o,
   output logic [DW-1:0]         m_dat_o,
   output logic [AW-1:0]         s_adr_o,
   output logic [DW-1:0]         s_dat_o,
   output logic [DW/8-1:0]       s_sel_o,
   output logic                  s_we_o,
   output logic [2:0]            s_cti_o,
   output logic [1:0]            s_bte_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   input  logic                  s_ack_i,
   input  logic                  s_err_i,
   input  logic                  s_rty_i,
   input  logic [DW-1:0]         s_dat_i,
   output logic [NODES-1:0]      grant_o,
   output logic                  timeout_o
);

   localparam int IW = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int SW = DW / 8;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

   state_t        r_state, w_next;
   logic [IW-1:0] r_owner, r_ptr, w_pick, w_owner_nxt, w_ptr_nxt;
   logic [CW-1:0] r_wcnt, w_wcnt_nxt;
   logic          w_any, w_cyc_g, w_stb_g, w_resp, w_count, w_fire;

   // First requester after the last owner wins; iterating downward lets the nearest overwrite.
   always_comb begin
      int idx;
      idx    = 0;
      w_pick = r_ptr;
      for (int k = NODES; k >= 1; k--) begin
         idx = (int'(r_ptr) + k) % NODES;
         if (m_cyc_i[idx]) w_pick = IW'(idx);
      end
   end

   assign w_any   = |m_cyc_i;
   assign w_cyc_g = m_cyc_i[r_owner];
   assign w_stb_g = m_stb_i[r_owner];
   assign w_resp  = s_ack_i | s_err_i | s_rty_i;
   assign w_count = (r_state == OWN) && w_cyc_g && w_stb_g && !w_resp;
   assign w_fire  = (TIMEOUT != 0) && w_count && (r_wcnt == CW'(TIMEOUT));

   assign w_wcnt_nxt = !w_count ? '0 :
                       (r_wcnt == CW'(TIMEOUT)) ? r_wcnt : r_wcnt + 1'b1;

   assign s_adr_o = m_adr_i[int'(r_owner)*AW +: AW];
   assign s_dat_o = m_dat_i[int'(r_owner)*DW +: DW];
   assign s_sel_o = m_sel_i[int'(r_owner)*SW +: SW];
   assign s_we_o  = m_we_i[r_owner];
   assign s_cti_o = m_cti_i[int'(r_owner)*3 +: 3];
   assign s_bte_o = m_bte_i[int'(r_owner)*2 +: 2];
   assign m_dat_o = s_dat_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_ptr   <= IW'(NODES - 1);
         r_wcnt  <= '0;
      end else begin
         r_state <= w_next;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      s_cyc_o     = 1'b0;
      s_stb_o     = 1'b0;
      m_ack_o     = '0;
      m_err_o     = '0;
      m_rty_o     = '0;
      grant_o     = '0;
      timeout_o   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_next      = OWN;
               w_owner_nxt = w_pick;
            end
         end
         OWN: begin
            grant_o[r_owner] = 1'b1;
            s_cyc_o          = w_cyc_g;
            s_stb_o          = w_stb_g;
            m_ack_o[r_owner] = s_ack_i;
            m_err_o[r_owner] = s_err_i;
            m_rty_o[r_owner] = s_rty_i;
            if (!w_cyc_g) begin
               w_next    = IDLE;
               w_ptr_nxt = r_owner;
            end else if (w_fire) begin
               // Drop the slave cycle immediately so the dead slave is released this cycle.
               s_cyc_o          = 1'b0;
               s_stb_o          = 1'b0;
               m_err_o[r_owner] = 1'b1;
               timeout_o        = 1'b1;
               w_next           = ABORT;
            end
         end
         ABORT: begin
            grant_o[r_owner] = 1'b1;
            if (!w_cyc_g) begin
               w_next    = IDLE;
               w_ptr_nxt = r_owner;
            end
         end
         default: w_next = IDLE;
      endcase
   end

endmodule
